// File: rtl/quad_position_ctrl.sv
// Closed-loop step/dir sequencer driving one stepper axis to a commanded encoder position.
// Latency: accept -> EVAL next cycle; step/dir/done are registered; the step period is measured rising edge to rising edge.
// Backpressure: cmd_ready is high only in IDLE; the host holds cmd_valid until it is accepted.
module quad_position_ctrl #(
    parameter int COUNT_BITS  = 32,
    parameter int DIV_BITS    = 16,
    parameter int STEP_PULSE  = 4,
    parameter int DIR_SETUP   = 2,
    parameter int STALL_STEPS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [COUNT_BITS-1:0] enc_count,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic signed [COUNT_BITS-1:0] cmd_target,
    input  logic [DIV_BITS-1:0]          cmd_period,
    input  logic                         abort,
    input  logic                         fault_clr,
    output logic                         step,
    output logic                         dir,
    output logic                         busy,
    output logic                         done,
    output logic                         fault
);

    localparam int STALL_W = $clog2(STALL_STEPS + 1);
    localparam logic [DIV_BITS-1:0] MIN_PERIOD = DIV_BITS'(STEP_PULSE + 1);
    localparam logic [DIV_BITS-1:0] PULSE_LAST = DIV_BITS'(STEP_PULSE - 1);
    localparam logic [DIV_BITS-1:0] SETUP_LAST = DIV_BITS'(DIR_SETUP - 1);
    localparam logic [STALL_W-1:0]  STALL_MAX  = STALL_W'(STALL_STEPS);

    typedef enum logic [2:0] {
        S_IDLE, S_EVAL, S_SETUP, S_HIGH, S_LOW, S_FAULT
    } state_t;

    state_t                      state, state_nx;
    logic [DIV_BITS-1:0]         cnt, cnt_nx;
    logic signed [COUNT_BITS-1:0] target_q;
    logic signed [COUNT_BITS-1:0] enc_prev;
    logic [DIV_BITS-1:0]         period_q;
    logic [STALL_W-1:0]          stall_cnt;
    logic                        first_step;
    logic signed [COUNT_BITS:0]  err;
    logic                        err_zero, want_dir, stalled, accept;
    logic [DIV_BITS-1:0]         low_len;
    logic                        step_nx, dir_nx, done_nx;

    // One extra bit keeps target - count exact even at opposite extremes.
    assign err      = $signed({target_q[COUNT_BITS-1], target_q}) -
                      $signed({enc_count[COUNT_BITS-1], enc_count});
    assign err_zero = (err == '0);
    assign want_dir = !err[COUNT_BITS] && !err_zero;
    assign stalled  = (stall_cnt >= STALL_MAX);
    assign accept   = cmd_valid && cmd_ready;
    // EVAL occupies the last low cycle, so LOW itself is one cycle shorter.
    assign low_len  = period_q - MIN_PERIOD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            step  <= step_nx;
            dir   <= dir_nx;
            done  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (cmd_valid) state_nx = S_EVAL;
            end
            S_EVAL: begin
                if (stalled && !err_zero) begin
                    state_nx = S_FAULT;
                end else if (err_zero) begin
                    state_nx = S_IDLE;
                end else if (want_dir != dir || first_step) begin
                    state_nx = S_SETUP;
                    cnt_nx   = SETUP_LAST;
                end else begin
                    state_nx = S_HIGH;
                    cnt_nx   = PULSE_LAST;
                end
            end
            S_SETUP: begin
                if (cnt == '0) begin
                    state_nx = S_HIGH;
                    cnt_nx   = PULSE_LAST;
                end else begin
                    cnt_nx = cnt - DIV_BITS'(1);
                end
            end
            S_HIGH: begin
                if (cnt == '0) begin
                    if (low_len == '0) begin
                        state_nx = S_EVAL;
                    end else begin
                        state_nx = S_LOW;
                        cnt_nx   = low_len - DIV_BITS'(1);
                    end
                end else begin
                    cnt_nx = cnt - DIV_BITS'(1);
                end
            end
            S_LOW: begin
                if (cnt == '0) state_nx = S_EVAL;
                else           cnt_nx   = cnt - DIV_BITS'(1);
            end
            S_FAULT: begin
                if (fault_clr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE && state != S_FAULT) state_nx = S_IDLE;
    end

    always_comb begin
        busy      = (state != S_IDLE);
        fault     = (state == S_FAULT);
        cmd_ready = (state == S_IDLE);
        step_nx   = (state_nx == S_HIGH);
        done_nx   = (state == S_EVAL) && (state_nx == S_IDLE) && !abort;
        dir_nx    = (state == S_EVAL && state_nx == S_SETUP) ? want_dir : dir;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            period_q   <= MIN_PERIOD;
            enc_prev   <= '0;
            stall_cnt  <= '0;
            first_step <= 1'b0;
        end else begin
            enc_prev <= enc_count;
            if (accept) begin
                target_q   <= cmd_target;
                period_q   <= (cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd_period;
                first_step <= 1'b1;
            end else if (state_nx == S_HIGH) begin
                first_step <= 1'b0;
            end
            // Any encoder movement proves the axis is alive.
            if (accept || enc_count != enc_prev) begin
                stall_cnt <= '0;
            end else if (state_nx == S_HIGH && state != S_HIGH && stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_quad_position_ctrl.sv
// Directed bench for quad_position_ctrl with a behavioural encoder that follows step falling edges.
module tb_quad_position_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [31:0] enc_count = '0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic signed [31:0] cmd_target = '0;
    logic [15:0]        cmd_period = '0;
    logic               abort = 1'b0;
    logic               fault_clr = 1'b0;
    logic               step, dir, busy, done, fault;

    quad_position_ctrl #(
        .COUNT_BITS(32), .DIV_BITS(16), .STEP_PULSE(4), .DIR_SETUP(2), .STALL_STEPS(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enc_count(enc_count),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
        .cmd_period(cmd_period), .abort(abort), .fault_clr(fault_clr),
        .step(step), .dir(dir), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cnt, done_cnt, dir_chg_cnt, last_rise, last_gap, last_dir_chg;
    int   min_dgap, hi_len, last_width;
    int   enc_mv = 0;
    logic step_q = 1'b0;
    logic dir_q = 1'b0;
    logic dsave;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, update the monitor and move the encoder.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (dir !== dir_q) begin
            last_dir_chg = cyc;
            dir_chg_cnt++;
        end
        if (step && !step_q) begin
            if (rise_cnt > 0) last_gap = cyc - last_rise;
            if (cyc - last_dir_chg < min_dgap) min_dgap = cyc - last_dir_chg;
            rise_cnt++;
            last_rise = cyc;
            hi_len = 0;
        end
        if (step) hi_len++;
        if (!step && step_q) begin
            last_width = hi_len;
            if (enc_mv != 0) enc_count = dir ? enc_count + enc_mv : enc_count - enc_mv;
        end
        if (done) done_cnt++;
        step_q = step;
        dir_q  = dir;
    endtask

    task automatic clr_mon();
        rise_cnt = 0; done_cnt = 0; dir_chg_cnt = 0; last_gap = 0; last_width = 0;
        min_dgap = 1000; hi_len = 0; last_rise = 0; last_dir_chg = -1000;
    endtask

    task automatic send(input logic signed [31:0] t, input logic [15:0] p);
        cmd_target = t;
        cmd_period = p;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic wait_step(input string tag, input logic lvl, input int budget);
        int n;
        n = 0;
        while (step !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk(tag, step, lvl);
    endtask

    initial begin
        clr_mon();
        // Reset values
        repeat (3) tick();
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;
        tick();

        // 0 -> 3, period 10
        clr_mon();
        enc_mv = 1;
        send(3, 16'd10);
        chk("t1_ready_low", cmd_ready, 0);
        wait_idle("t1_idle", 200);
        chk("t1_rises", rise_cnt, 3);
        chk("t1_gap", last_gap, 10);
        chk("t1_width", last_width, 4);
        chk("t1_dir_setup", min_dgap, 2);
        chk("t1_dir", dir, 1);
        chk("t1_done_now", done, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_enc", enc_count, 3);
        chk("t1_ready", cmd_ready, 1);
        tick();
        chk("t1_done_pulse", done, 0);

        // Already at target
        enc_mv = 0;
        enc_count = 100;
        tick();
        clr_mon();
        send(100, 16'd10);
        chk("t2_busy", busy, 1);
        chk("t2_done_early", done, 0);
        tick();
        chk("t2_busy_drop", busy, 0);
        chk("t2_done", done, 1);
        tick();
        chk("t2_done_pulse", done, 0);
        chk("t2_rises", rise_cnt, 0);

        // 0 -> -2, period 2 clamped to 5
        enc_count = 0;
        enc_mv = 1;
        tick();
        clr_mon();
        send(-2, 16'd2);
        wait_idle("t3_idle", 200);
        chk("t3_dir", dir, 0);
        chk("t3_rises", rise_cnt, 2);
        chk("t3_gap", last_gap, 5);
        chk("t3_width", last_width, 4);
        chk("t3_dir_setup", min_dgap, 2);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_enc", enc_count, -2);

        // Frozen encoder -> stall fault
        enc_mv = 0;
        tick();
        clr_mon();
        send(50, 16'd6);
        begin
            int n;
            n = 0;
            while (!fault && n < 300) begin
                tick();
                n++;
            end
        end
        chk("t4_fault", fault, 1);
        chk("t4_rises", rise_cnt, 8);
        chk("t4_step", step, 0);
        chk("t4_busy", busy, 1);
        chk("t4_ready", cmd_ready, 0);
        repeat (5) tick();
        chk("t4_rises_held", rise_cnt, 8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_abort_ignored", fault, 1);
        abort = 1'b1;
        fault_clr = 1'b1;
        tick();
        abort = 1'b0;
        fault_clr = 1'b0;
        chk("t4_clr_fault", fault, 0);
        chk("t4_clr_ready", cmd_ready, 1);
        chk("t4_clr_busy", busy, 0);
        chk("t4_no_done", done_cnt, 0);

        // Overshoot: each step moves 2 counts, target 3 keeps reversing
        enc_count = 0;
        enc_mv = 2;
        tick();
        clr_mon();
        send(3, 16'd6);
        repeat (100) tick();
        wait_step("t5_step_hi", 1'b1, 50);
        dsave = dir;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_step", step, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_dir", dir, dsave);
        chk("t5_dir_setup", min_dgap, 2);
        chk("t5_reversals", (dir_chg_cnt >= 3), 1);
        chk("t5_no_done", done_cnt, 0);
        tick();
        chk("t5_no_done_after", done, 0);

        // Reset while in LOW
        enc_count = 0;
        enc_mv = 1;
        tick();
        send(5, 16'd10);
        wait_step("t6_hi", 1'b1, 50);
        wait_step("t6_lo", 1'b0, 50);
        chk("t6_dir_before", dir, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_step", step, 0);
        chk("t6_rst_dir", dir, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", cmd_ready, 1);
        chk("t6_rst_fault", fault, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while step is high
        send(5, 16'd10);
        wait_step("t7_hi", 1'b1, 50);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_step", step, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
